hid_motion_pattern_gen: RTL and testbench
=========================================

Name: hid_motion_pattern_gen

Overview:
Parametrised synthetic mouse-motion source for the USB HID mouse emulator. It generates motion deltas per report tick from a selectable pattern: circle, square, figure-8, pseudo-random or idle. Deltas are accumulated with saturation while the downstream report builder stalls. Reports are issued over a valid/ready handshake, and a change on the button inputs also triggers a report.

Parameters:
TICKS_PER_REPORT, 480000, clk cycles between motion ticks (48 MHz / 100 Hz)
DELTA_W, 8, signed width of dx/dy (2..16)
TICK_CNT_W, 20, tick counter width (must hold TICKS_PER_REPORT-1)
LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = tick counter runs
pattern_sel  in  3  0 circle, 1 square, 2 figure-8, 3 random, 4-7 idle (zero delta)
speed  in  4  phase increment per tick; 0 treated as 1
scale_shift  in  3  arithmetic right shift applied to pattern amplitude
buttons_in  in  3  live button state, synchronous to clk
report_valid  out  1  report available
report_ready  in  1  consumer accepts report
dx  out  DELTA_W  signed X delta, stable while valid && !ready
dy  out  DELTA_W  signed Y delta, stable while valid && !ready
buttons  out  3  button state carried by the report
sat_flag  out  1  sticky: an accumulator saturated since the last report load

Behaviour:
- Reset (async, rst_n=0): report_valid=0, dx=dy=0, buttons=0, sat_flag=0. Internal state: tick_cnt=0, phase=0, acc_x=acc_y=0, pending=0, lfsr=LFSR_SEED, btn_last=0.
- Tick counter: when enable=1, counts 0..TICKS_PER_REPORT-1. tick is asserted for one cycle when cnt==TICKS_PER_REPORT-1, and cnt wraps to 0. When enable=0, cnt is forced to 0 and no ticks occur. Pending and accumulated data still drain while enable=0.
- Sine: 64-entry quarter-wave LUT, lut[i]=round(127*sin(i*pi/128)), 8-bit phase.
  - sin(p): quadrant p[7:6] gives 0:+lut[p5:0], 1:+lut[63-p5:0], 2:-lut[p5:0], 3:-lut[63-p5:0].
  - cos(p)=sin(p+64 mod 256).
  - Results are 8-bit signed, then sign-extended to DELTA_W, then shifted arithmetically right by scale_shift.
- Tick delta (tdx, tdy), evaluated with the current phase:
  - circle: tdx=cos(p), tdy=sin(p)
  - square: M=127>>>s; quadrant 0:(+M,0), 1:(0,+M), 2:(-M,0), 3:(0,-M)
  - figure-8: tdx=cos(p), tdy=cos(2p mod 256)
  - random: tdx=lfsr[3:0]-8, tdy=lfsr[7:4]-8 (range -8..7, unscaled)
  - idle: (0,0)
- On each tick: phase += max(speed,1), modulo 256. The LFSR shifts {lfsr[14:0], lfsr15^lfsr13^lfsr12^lfsr10}; the pre-shift value is used for the delta. Phase and LFSR advance only on ticks.
- nx = sat(acc_x + (tick ? tdx : 0)); ny likewise.
  - Saturation range is ±(2^(DELTA_W-1)-1); for DELTA_W=8 this is -127..127 (-128 is never produced).
  - Any clipping sets sat_flag.
- btn_chg = (buttons_in != btn_last).
- event = tick || btn_chg || pending.
- load = event && (!report_valid || report_ready).
- On load:
  - dx<=nx, dy<=ny, buttons<=buttons_in, btn_last<=buttons_in
  - acc<=0, pending<=0, report_valid<=1
  - sat_flag clears unless this cycle saturated
- On event without load: acc<=nx, pending<=1.
- Handshake completing with no event: report_valid<=0.
- Latency: tick or button change in cycle C makes report_valid=1 visible at C+1 when the output slot is free.
- Back-to-back: valid&&ready coinciding with an event reloads in the same cycle, so valid stays 1. No delta is lost or counted twice.
- pattern_sel, speed and scale_shift are sampled only on tick cycles. Changing them never resets phase.
- Reset mid-stall discards all accumulated motion.

Test Plan:
- Bench TICKS_PER_REPORT=10, circle, speed=1, s=3, ready=1 -> first report at cycle 10: dx=15, dy=0. Ticks at phase 64 and 128: dx=0,dy=15, then dx=-16,dy=0.
- Square, speed=64, s=3 -> successive reports (15,0), (0,15), (-16,0), (0,-16), then repeat.
- Random, first tick -> dx=-7, dy=6 (seed ACE1). Second report uses the shifted LFSR.
- Circle speed=1 s=0, ready=0 for 3 ticks, then ready=1 -> one report with dx=127 (saturated 381), sat_flag=1. sat_flag clears on the next clean load.
- Idle, buttons_in 000->001 in cycle C -> report_valid=1 at C+1 with buttons=001, dx=dy=0. Holding buttons constant produces no further button-triggered reports.
- Tick coincident with valid&&ready -> valid stays 1 and new deltas appear next cycle. Toggle rst_n mid-stall -> all outputs 0 and no stale report follows.

Source files
------------

// File: rtl/hid_motion_pattern_gen_if.sv
// Report channel between the motion pattern generator and the HID report builder.
//   report_valid : a motion/button report is waiting
//   report_ready : the consumer accepts the report this cycle
//   dx, dy       : signed motion deltas, held while valid && !ready
//   buttons      : button state carried by the report
//   sat_flag     : an accumulator clipped while building this report
interface hid_motion_pattern_gen_if #(
  parameter int unsigned DELTA_W = 8
);
  logic                      report_valid;
  logic                      report_ready;
  logic signed [DELTA_W-1:0] dx;
  logic signed [DELTA_W-1:0] dy;
  logic [2:0]                buttons;
  logic                      sat_flag;

  modport master (output report_valid, dx, dy, buttons, sat_flag, input report_ready);
  modport slave  (input report_valid, dx, dy, buttons, sat_flag, output report_ready);
endinterface

// File: rtl/hid_motion_pattern_gen.sv
// Synthetic mouse-motion source: produces per-tick deltas from a circle,
// square, figure-8, pseudo-random or idle pattern, accumulates them with
// saturation while the report builder stalls, and issues reports on a
// valid/ready channel. A button change also triggers a report.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_enable        : tick counter runs
//   i_pattern_sel   : 0 circle, 1 square, 2 figure-8, 3 random, 4-7 idle
//   i_speed         : phase increment per tick (0 behaves as 1)
//   i_scale_shift   : arithmetic right shift of pattern amplitude
//   i_buttons_in    : live button state
//   rpt             : report channel (master side)
module hid_motion_pattern_gen #(
  parameter int unsigned TICKS_PER_REPORT = 480000,
  parameter int unsigned DELTA_W          = 8,
  parameter int unsigned TICK_CNT_W       = 20,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic [2:0]                i_pattern_sel,
  input  logic [3:0]                i_speed,
  input  logic [2:0]                i_scale_shift,
  input  logic [2:0]                i_buttons_in,
  hid_motion_pattern_gen_if.master  rpt
);

  // Tick deltas live in at least 8 bits; one extra bit holds acc + delta.
  localparam int unsigned EXT_W = (DELTA_W > 8) ? DELTA_W : 8;
  localparam int unsigned SUM_W = EXT_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (DELTA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;

  // Quarter-wave table: round(127 * sin(i * pi / 128)).
  localparam logic signed [7:0] SIN_LUT [64] = '{
    8'sd0,   8'sd3,   8'sd6,   8'sd9,   8'sd12,  8'sd16,  8'sd19,  8'sd22,
    8'sd25,  8'sd28,  8'sd31,  8'sd34,  8'sd37,  8'sd40,  8'sd43,  8'sd46,
    8'sd49,  8'sd51,  8'sd54,  8'sd57,  8'sd60,  8'sd63,  8'sd65,  8'sd68,
    8'sd71,  8'sd73,  8'sd76,  8'sd78,  8'sd81,  8'sd83,  8'sd85,  8'sd88,
    8'sd90,  8'sd92,  8'sd94,  8'sd96,  8'sd98,  8'sd100, 8'sd102, 8'sd104,
    8'sd106, 8'sd107, 8'sd109, 8'sd111, 8'sd112, 8'sd113, 8'sd115, 8'sd116,
    8'sd117, 8'sd118, 8'sd120, 8'sd121, 8'sd122, 8'sd122, 8'sd123, 8'sd124,
    8'sd125, 8'sd125, 8'sd126, 8'sd126, 8'sd126, 8'sd127, 8'sd127, 8'sd127
  };

  function automatic logic signed [7:0] f_sin(input logic [7:0] p);
    logic [5:0]        idx;
    logic signed [7:0] mag;
    idx = p[6] ? 6'(6'd63 - p[5:0]) : p[5:0];
    mag = SIN_LUT[idx];
    return p[7] ? -mag : mag;
  endfunction

  // Sign-extend to the working width, then shift arithmetically.
  function automatic logic signed [EXT_W-1:0] f_scale(input logic signed [7:0] v,
                                                      input logic [2:0] s);
    logic signed [EXT_W-1:0] e;
    e = EXT_W'(v);
    return e >>> s;
  endfunction

  logic [TICK_CNT_W-1:0]     r_tick_cnt;
  logic [7:0]                r_phase;
  logic [15:0]               r_lfsr;
  logic signed [DELTA_W-1:0] r_acc_x, r_acc_y;
  logic                      r_pending;
  logic                      r_sat_acc;
  logic [2:0]                r_btn_last;
  logic                      r_valid;
  logic signed [DELTA_W-1:0] r_dx, r_dy;
  logic [2:0]                r_buttons;
  logic                      r_sat_flag;

  logic                      w_tick, w_btn_chg, w_event, w_load;
  logic [7:0]                w_step;
  logic signed [7:0]         w_cos_p, w_sin_p, w_cos_2p;
  logic signed [4:0]         w_rnd_x, w_rnd_y;
  logic signed [EXT_W-1:0]   w_tdx, w_tdy;
  logic signed [SUM_W-1:0]   w_sum_x, w_sum_y;
  logic signed [DELTA_W-1:0] w_nx, w_ny;
  logic                      w_sat_now;

  assign w_tick    = i_enable && (r_tick_cnt == TICK_CNT_W'(TICKS_PER_REPORT - 1));
  assign w_step    = (i_speed == 4'd0) ? 8'd1 : {4'd0, i_speed};
  assign w_cos_p   = f_sin(r_phase + 8'd64);
  assign w_sin_p   = f_sin(r_phase);
  assign w_cos_2p  = f_sin({r_phase[6:0], 1'b0} + 8'd64);
  assign w_rnd_x   = $signed({1'b0, r_lfsr[3:0]}) - 5'sd8;
  assign w_rnd_y   = $signed({1'b0, r_lfsr[7:4]}) - 5'sd8;
  assign w_btn_chg = (i_buttons_in != r_btn_last);
  assign w_event   = w_tick || w_btn_chg || r_pending;
  assign w_load    = w_event && (!r_valid || rpt.report_ready);

  // Per-tick delta for the selected pattern at the current phase.
  // The square's negative sides shift -127, so they match the circle's
  // cardinal points.
  always_comb begin
    w_tdx = '0;
    w_tdy = '0;
    case (i_pattern_sel)
      3'd0: begin
        w_tdx = f_scale(w_cos_p, i_scale_shift);
        w_tdy = f_scale(w_sin_p, i_scale_shift);
      end
      3'd1: begin
        case (r_phase[7:6])
          2'd0:    w_tdx = f_scale(8'sd127, i_scale_shift);
          2'd1:    w_tdy = f_scale(8'sd127, i_scale_shift);
          2'd2:    w_tdx = f_scale(-8'sd127, i_scale_shift);
          default: w_tdy = f_scale(-8'sd127, i_scale_shift);
        endcase
      end
      3'd2: begin
        w_tdx = f_scale(w_cos_p, i_scale_shift);
        w_tdy = f_scale(w_cos_2p, i_scale_shift);
      end
      3'd3: begin
        w_tdx = EXT_W'(w_rnd_x);
        w_tdy = EXT_W'(w_rnd_y);
      end
      default: ;
    endcase
  end

  // Accumulate this cycle's delta and clip to the symmetric range.
  always_comb begin
    w_sum_x   = SUM_W'(r_acc_x) + (w_tick ? SUM_W'(w_tdx) : '0);
    w_sum_y   = SUM_W'(r_acc_y) + (w_tick ? SUM_W'(w_tdy) : '0);
    w_sat_now = 1'b0;
    w_nx      = w_sum_x[DELTA_W-1:0];
    w_ny      = w_sum_y[DELTA_W-1:0];
    if (w_sum_x > SAT_HI) begin
      w_nx = SAT_HI[DELTA_W-1:0]; w_sat_now = 1'b1;
    end else if (w_sum_x < SAT_LO) begin
      w_nx = SAT_LO[DELTA_W-1:0]; w_sat_now = 1'b1;
    end
    if (w_sum_y > SAT_HI) begin
      w_ny = SAT_HI[DELTA_W-1:0]; w_sat_now = 1'b1;
    end else if (w_sum_y < SAT_LO) begin
      w_ny = SAT_LO[DELTA_W-1:0]; w_sat_now = 1'b1;
    end
  end

  // Tick counter, phase and LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_phase    <= '0;
      r_lfsr     <= LFSR_SEED;
    end else begin
      if (!i_enable || w_tick) r_tick_cnt <= '0;
      else                     r_tick_cnt <= r_tick_cnt + 1'b1;
      if (w_tick) begin
        r_phase <= r_phase + w_step;
        r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
    end
  end

  // Report slot: load when free or being consumed, otherwise park in the accumulator.
  // sat_flag reports clipping that happened anywhere in the loaded report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_pending  <= 1'b0;
      r_sat_acc  <= 1'b0;
      r_btn_last <= '0;
      r_valid    <= 1'b0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_buttons  <= '0;
      r_sat_flag <= 1'b0;
    end else if (w_load) begin
      r_dx       <= w_nx;
      r_dy       <= w_ny;
      r_buttons  <= i_buttons_in;
      r_btn_last <= i_buttons_in;
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_pending  <= 1'b0;
      r_valid    <= 1'b1;
      r_sat_flag <= r_sat_acc || w_sat_now;
      r_sat_acc  <= 1'b0;
    end else if (w_event) begin
      r_acc_x    <= w_nx;
      r_acc_y    <= w_ny;
      r_pending  <= 1'b1;
      r_sat_acc  <= r_sat_acc || w_sat_now;
    end else if (r_valid && rpt.report_ready) begin
      r_valid    <= 1'b0;
    end
  end

  assign rpt.report_valid = r_valid;
  assign rpt.dx           = r_dx;
  assign rpt.dy           = r_dy;
  assign rpt.buttons      = r_buttons;
  assign rpt.sat_flag     = r_sat_flag;

endmodule

// File: tb/tb_hid_motion_pattern_gen.sv
// Directed bench for hid_motion_pattern_gen with a 10-cycle tick period.
module tb_hid_motion_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [2:0] pattern_sel;
  logic [3:0] speed;
  logic [2:0] scale_shift;
  logic [2:0] buttons_in;

  int n_cmp = 0;
  int n_err = 0;

  hid_motion_pattern_gen_if #(.DELTA_W(8)) u_if ();

  hid_motion_pattern_gen #(
    .TICKS_PER_REPORT(10),
    .DELTA_W(8),
    .TICK_CNT_W(4),
    .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_enable(enable),
    .i_pattern_sel(pattern_sel),
    .i_speed(speed),
    .i_scale_shift(scale_shift),
    .i_buttons_in(buttons_in),
    .rpt(u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pat;
    logic [3:0] spd;
    logic [2:0] sh;
    int         exp_dx;
    int         exp_dy;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_report(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (u_if.report_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    buttons_in = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int cnt;

    // pattern, speed, shift, dx, dy -- one tick each, phase walks through all quadrants
    vecs[0]  = '{3'd0, 4'd15, 3'd3,  15,   0};  // circle @0
    vecs[1]  = '{3'd3, 4'd15, 3'd0,  -5,   4};  // random, lfsr 59C3
    vecs[2]  = '{3'd4, 4'd15, 3'd0,   0,   0};  // idle @30
    vecs[3]  = '{3'd5, 4'd15, 3'd0,   0,   0};
    vecs[4]  = '{3'd7, 4'd4,  3'd0,   0,   0};  // -> 64
    vecs[5]  = '{3'd0, 4'd15, 3'd3,   0,  15};  // circle @64
    vecs[6]  = '{3'd1, 4'd15, 3'd3,   0,  15};  // square @79
    vecs[7]  = '{3'd4, 4'd15, 3'd0,   0,   0};
    vecs[8]  = '{3'd4, 4'd15, 3'd0,   0,   0};
    vecs[9]  = '{3'd6, 4'd4,  3'd0,   0,   0};  // -> 128
    vecs[10] = '{3'd1, 4'd15, 3'd3, -16,   0};  // square @128
    vecs[11] = '{3'd0, 4'd15, 3'd3, -15,  -6};  // circle @143
    vecs[12] = '{3'd4, 4'd15, 3'd0,   0,   0};
    vecs[13] = '{3'd4, 4'd15, 3'd0,   0,   0};
    vecs[14] = '{3'd4, 4'd4,  3'd0,   0,   0};  // -> 192
    vecs[15] = '{3'd1, 4'd15, 3'd3,   0, -16};  // square @192
    vecs[16] = '{3'd2, 4'd0,  3'd0,  46, -92};  // figure-8 @207, speed 0 -> 1
    vecs[17] = '{3'd0, 4'd5,  3'd1,  24, -58};  // circle @208

    rst_n = 1'b0; enable = 1'b0; pattern_sel = 3'd0; speed = 4'd1;
    scale_shift = 3'd0; buttons_in = 3'b000; u_if.report_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid",   int'(u_if.report_valid), 0);
    check("rst_dx",      int'(u_if.dx), 0);
    check("rst_dy",      int'(u_if.dy), 0);
    check("rst_buttons", int'(u_if.buttons), 0);
    check("rst_sat",     int'(u_if.sat_flag), 0);
    rst_n = 1'b1;

    // Free-running pattern table, consumer always ready
    enable = 1'b1;
    for (int i = 0; i < 18; i++) begin
      pattern_sel = vecs[i].pat;
      speed       = vecs[i].spd;
      scale_shift = vecs[i].sh;
      wait_report(got);
      check($sformatf("vec%0d_seen", i), int'(got), 1);
      check($sformatf("vec%0d_dx", i), int'(u_if.dx), vecs[i].exp_dx);
      check($sformatf("vec%0d_dy", i), int'(u_if.dy), vecs[i].exp_dy);
    end

    // Random from seed: first tick uses ACE1
    do_reset();
    pattern_sel = 3'd3; speed = 4'd1; enable = 1'b1;
    wait_report(got);
    check("rnd_seen", int'(got), 1);
    check("rnd_dx", int'(u_if.dx), -7);
    check("rnd_dy", int'(u_if.dy), 6);

    // Button change: report one cycle later, no repeat while held
    do_reset();
    pattern_sel = 3'd4;
    @(negedge clk);
    check("btn_idle_valid", int'(u_if.report_valid), 0);
    buttons_in = 3'b001;
    @(negedge clk);
    check("btn_valid",   int'(u_if.report_valid), 1);
    check("btn_buttons", int'(u_if.buttons), 1);
    check("btn_dx",      int'(u_if.dx), 0);
    check("btn_dy",      int'(u_if.dy), 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (u_if.report_valid) cnt++;
    end
    check("btn_no_repeat", cnt, 0);

    // Saturation across a stall: button report occupies the slot, three ticks pile up
    do_reset();
    pattern_sel = 3'd0; speed = 4'd1; scale_shift = 3'd0;
    u_if.report_ready = 1'b0;
    buttons_in = 3'b010;
    @(negedge clk);
    check("sat_slot_valid", int'(u_if.report_valid), 1);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    check("sat_hold_valid", int'(u_if.report_valid), 1);
    check("sat_hold_dx",    int'(u_if.dx), 0);
    enable = 1'b0;
    u_if.report_ready = 1'b1;
    @(negedge clk);
    check("sat_valid", int'(u_if.report_valid), 1);
    check("sat_dx",    int'(u_if.dx), 127);
    check("sat_dy",    int'(u_if.dy), 9);
    check("sat_flag",  int'(u_if.sat_flag), 1);
    @(negedge clk);
    check("sat_drain_valid", int'(u_if.report_valid), 0);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("clean_valid", int'(u_if.report_valid), 1);
    check("clean_dx",    int'(u_if.dx), 126);
    check("clean_dy",    int'(u_if.dy), 9);
    check("clean_sat",   int'(u_if.sat_flag), 0);

    // Tick landing on a completing handshake: valid stays high with new data
    do_reset();
    pattern_sel = 3'd0; speed = 4'd15; scale_shift = 3'd3;
    enable = 1'b1;
    repeat (8) @(negedge clk);
    buttons_in = 3'b100;
    @(negedge clk);
    check("b2b_btn_valid", int'(u_if.report_valid), 1);
    check("b2b_btn_dx",    int'(u_if.dx), 0);
    check("b2b_btn_bt",    int'(u_if.buttons), 4);
    @(negedge clk);
    check("b2b_tick_valid", int'(u_if.report_valid), 1);
    check("b2b_tick_dx",    int'(u_if.dx), 15);
    check("b2b_tick_dy",    int'(u_if.dy), 0);

    // Reset in the middle of a stall discards everything
    do_reset();
    pattern_sel = 3'd0; speed = 4'd1; scale_shift = 3'd0;
    u_if.report_ready = 1'b0;
    enable = 1'b1;
    repeat (25) @(negedge clk);
    check("stall_valid", int'(u_if.report_valid), 1);
    check("stall_dx",    int'(u_if.dx), 127);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", int'(u_if.report_valid), 0);
    check("mid_rst_dx",    int'(u_if.dx), 0);
    check("mid_rst_dy",    int'(u_if.dy), 0);
    check("mid_rst_sat",   int'(u_if.sat_flag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    u_if.report_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (u_if.report_valid) cnt++;
    end
    check("no_stale_rpt", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
